// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush scheduler: FSM states, stage
// register indices and the bundled control word with its canned patterns.
package pipeline_ctrl_pkg;

  localparam int unsigned MDU_CYCLES_DEF = 34;
  localparam int unsigned CNT_W_DEF      = 6;

  localparam int unsigned IF_ID  = 0;
  localparam int unsigned ID_EX  = 1;
  localparam int unsigned EX_MEM = 2;
  localparam int unsigned MEM_WB = 3;

  typedef enum logic [1:0] {
    RUN,
    DMEM_WAIT,
    MDU_WAIT,
    REDIR_WAIT
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] flush;
    logic       redirect_hold;
    logic       mdu_done;
  } ctrl_t;

  function automatic ctrl_t ctrl_advance();
    ctrl_t c;
    c.pc_en         = 1'b1;
    c.en            = 4'b1111;
    c.flush         = 4'b0000;
    c.redirect_hold = 1'b0;
    c.mdu_done      = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c.pc_en         = 1'b0;
    c.en            = 4'b0000;
    c.flush         = 4'b1111;
    c.redirect_hold = 1'b0;
    c.mdu_done      = 1'b0;
    return c;
  endfunction

  // Trap: redirect PC to the handler and squash everything younger than WB.
  function automatic ctrl_t ctrl_trap();
    ctrl_t c;
    c = ctrl_advance();
    c.flush[IF_ID]  = 1'b1;
    c.flush[ID_EX]  = 1'b1;
    c.flush[EX_MEM] = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_dmem_freeze();
    ctrl_t c;
    c = ctrl_advance();
    c.pc_en         = 1'b0;
    c.en            = 4'b0000;
    c.flush[MEM_WB] = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_mdu_hold();
    ctrl_t c;
    c = ctrl_advance();
    c.pc_en         = 1'b0;
    c.en[IF_ID]     = 1'b0;
    c.en[ID_EX]     = 1'b0;
    c.flush[EX_MEM] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_counter.sv
// Loadable down counter with zero flag; decrement saturates at zero so the
// MDU occupancy count can never wrap.
module ctrl_down_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && !zero)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the 5-stage core: merges hazard, branch,
// trap, memory handshake and MDU occupancy into PC and stage-register controls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MDU_CYCLES = MDU_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_ld,
  input  logic ex_multicycle,
  input  logic branch_taken,
  input  logic trap_wb,
  input  logic ifetch_ready,
  input  logic dmem_req,
  input  logic dmem_ready,
  output logic pc_en,
  output logic if_id_en,
  output logic if_id_flush,
  output logic id_ex_en,
  output logic id_ex_flush,
  output logic ex_mem_en,
  output logic ex_mem_flush,
  output logic mem_wb_en,
  output logic mem_wb_flush,
  output logic redirect_hold,
  output logic mdu_done
);

  // Entry cycle counts as the first of MDU_CYCLES, so the wait phase runs
  // MDU_CYCLES-2 decrements before the final done cycle at zero.
  localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 2);

  state_t           state_q, state_d;
  ctrl_t            ctrl;
  logic             mdu_block_q;
  logic             mdu_start;
  logic             dmem_stall;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  ctrl_down_counter #(.CNT_W(CNT_W)) u_mdu_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // A level still high after mdu_done belongs to the finished op.
  assign mdu_start  = ex_multicycle && !mdu_block_q;
  assign dmem_stall = dmem_req && !dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      mdu_block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ctrl.mdu_done)
        mdu_block_q <= 1'b1;
      else if (!ex_multicycle)
        mdu_block_q <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    ctrl         = ctrl_advance();
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      RUN: begin
        if (trap_wb) begin
          ctrl = ctrl_trap();
        end else if (dmem_stall) begin
          ctrl    = ctrl_dmem_freeze();
          state_d = DMEM_WAIT;
        end else if (mdu_start) begin
          ctrl         = ctrl_mdu_hold();
          cnt_load     = 1'b1;
          cnt_load_val = MDU_LOAD;
          state_d      = MDU_WAIT;
        end else if (branch_taken) begin
          ctrl.flush[IF_ID] = 1'b1;
          ctrl.flush[ID_EX] = 1'b1;
          if (!ifetch_ready) begin
            ctrl.pc_en         = 1'b0;
            ctrl.redirect_hold = 1'b1;
            state_d            = REDIR_WAIT;
          end
        end else if (stall_ld) begin
          ctrl.pc_en        = 1'b0;
          ctrl.en[IF_ID]    = 1'b0;
          ctrl.flush[ID_EX] = 1'b1;
        end else if (!ifetch_ready) begin
          ctrl.pc_en        = 1'b0;
          ctrl.flush[IF_ID] = 1'b1;
        end
      end

      DMEM_WAIT: begin
        if (!dmem_ready)
          ctrl = ctrl_dmem_freeze();
        else
          state_d = RUN;
      end

      MDU_WAIT: begin
        if (trap_wb) begin
          ctrl         = ctrl_trap();
          cnt_load     = 1'b1;
          cnt_load_val = '0;
          state_d      = RUN;
        end else if (cnt_zero) begin
          ctrl.mdu_done = 1'b1;
          state_d       = RUN;
        end else begin
          ctrl    = ctrl_mdu_hold();
          cnt_dec = 1'b1;
        end
      end

      REDIR_WAIT: begin
        if (trap_wb) begin
          ctrl    = ctrl_trap();
          state_d = RUN;
        end else begin
          // The word arriving on the ready cycle was fetched from the old
          // path, so IF/ID is bubbled even as the PC finally loads.
          ctrl.redirect_hold = 1'b1;
          ctrl.flush[IF_ID]  = 1'b1;
          ctrl.pc_en         = ifetch_ready;
          if (ifetch_ready)
            state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase

    ctrl.en = ctrl.en & ~ctrl.flush;

    if (rst) begin
      ctrl    = ctrl_reset();
      state_d = RUN;
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.en[IF_ID];
  assign if_id_flush   = ctrl.flush[IF_ID];
  assign id_ex_en      = ctrl.en[ID_EX];
  assign id_ex_flush   = ctrl.flush[ID_EX];
  assign ex_mem_en     = ctrl.en[EX_MEM];
  assign ex_mem_flush  = ctrl.flush[EX_MEM];
  assign mem_wb_en     = ctrl.en[MEM_WB];
  assign mem_wb_flush  = ctrl.flush[MEM_WB];
  assign redirect_hold = ctrl.redirect_hold;
  assign mdu_done      = ctrl.mdu_done;

  // WB always holds a bubble while a data access is outstanding.
  no_trap_in_dmem_wait: assert property (
    @(posedge clk) disable iff (rst) !(trap_wb && state_q == DMEM_WAIT)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a 4-cycle MDU; each vector carries a
// hand-computed expected control word.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_ld = 1'b0, ex_multicycle = 1'b0, branch_taken = 1'b0, trap_wb = 1'b0;
  logic ifetch_ready = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, redirect_hold, mdu_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MDU_CYCLES(4), .CNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_ld      (stall_ld),
    .ex_multicycle (ex_multicycle),
    .branch_taken  (branch_taken),
    .trap_wb       (trap_wb),
    .ifetch_ready  (ifetch_ready),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .if_id_flush   (if_id_flush),
    .id_ex_en      (id_ex_en),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_en     (ex_mem_en),
    .ex_mem_flush  (ex_mem_flush),
    .mem_wb_en     (mem_wb_en),
    .mem_wb_flush  (mem_wb_flush),
    .redirect_hold (redirect_hold),
    .mdu_done      (mdu_done)
  );

  // Stimulus bits: {stall_ld, ex_multicycle, branch_taken, trap_wb, ifetch_ready, dmem_req, dmem_ready}
  localparam logic [6:0] I_LD   = 7'b1000000;
  localparam logic [6:0] I_MUL  = 7'b0100000;
  localparam logic [6:0] I_BR   = 7'b0010000;
  localparam logic [6:0] I_TRAP = 7'b0001000;
  localparam logic [6:0] I_FR   = 7'b0000100;
  localparam logic [6:0] I_DREQ = 7'b0000010;
  localparam logic [6:0] I_DRDY = 7'b0000001;
  localparam logic [6:0] I_NONE = 7'b0000000;

  // Control word: {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl, hold, done}
  localparam logic [10:0] E_RESET      = 11'b0_01_01_01_01_0_0;
  localparam logic [10:0] E_RUN        = 11'b1_10_10_10_10_0_0;
  localparam logic [10:0] E_STALL      = 11'b0_00_01_10_10_0_0;
  localparam logic [10:0] E_NOFETCH    = 11'b0_01_10_10_10_0_0;
  localparam logic [10:0] E_DFREEZE    = 11'b0_00_00_00_01_0_0;
  localparam logic [10:0] E_MDUHOLD    = 11'b0_00_00_01_10_0_0;
  localparam logic [10:0] E_MDUDONE    = 11'b1_10_10_10_10_0_1;
  localparam logic [10:0] E_TRAP       = 11'b1_01_01_01_10_0_0;
  localparam logic [10:0] E_BR_READY   = 11'b1_01_01_10_10_0_0;
  localparam logic [10:0] E_BR_WAIT    = 11'b0_01_01_10_10_1_0;
  localparam logic [10:0] E_REDIR      = 11'b0_01_10_10_10_1_0;
  localparam logic [10:0] E_REDIR_RDY  = 11'b1_01_10_10_10_1_0;

  task automatic check(input string tag, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // One cycle: drive at negedge, compare the combinational outputs shortly after.
  task automatic cyc(input logic rst_v, input logic [6:0] stim,
                     input logic [10:0] exp, input string tag);
    @(negedge clk);
    rst = rst_v;
    {stall_ld, ex_multicycle, branch_taken, trap_wb, ifetch_ready, dmem_req, dmem_ready} = stim;
    #2;
    check(tag, {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
                mem_wb_en, mem_wb_flush, redirect_hold, mdu_done}, exp);
  endtask

  initial begin
    cyc(1'b1, I_FR, E_RESET, "reset0");
    cyc(1'b1, I_FR | I_MUL | I_BR, E_RESET, "reset1");

    for (int i = 0; i < 10; i++)
      cyc(1'b0, I_FR, E_RUN, "run");

    cyc(1'b0, I_FR | I_LD, E_STALL, "stall_ld");
    cyc(1'b0, I_FR, E_RUN, "stall_ld_after");
    cyc(1'b0, I_NONE, E_NOFETCH, "fetch_stall");

    cyc(1'b0, I_FR | I_DREQ, E_DFREEZE, "dmem_entry");
    cyc(1'b0, I_FR | I_DREQ, E_DFREEZE, "dmem_wait1");
    cyc(1'b0, I_FR | I_DREQ, E_DFREEZE, "dmem_wait2");
    cyc(1'b0, I_FR | I_DREQ | I_DRDY, E_RUN, "dmem_ready");
    cyc(1'b0, I_FR, E_RUN, "dmem_after");

    cyc(1'b0, I_FR | I_DREQ | I_MUL | I_BR | I_LD, E_DFREEZE, "prio_dmem");
    cyc(1'b0, I_FR | I_DREQ | I_DRDY, E_RUN, "prio_dmem_rdy");

    cyc(1'b0, I_FR | I_MUL, E_MDUHOLD, "mdu_c0");
    cyc(1'b0, I_FR | I_MUL, E_MDUHOLD, "mdu_c1");
    cyc(1'b0, I_FR | I_MUL, E_MDUHOLD, "mdu_c2");
    cyc(1'b0, I_FR | I_MUL, E_MDUDONE, "mdu_done");
    cyc(1'b0, I_FR | I_MUL, E_RUN, "mdu_level_hold");
    cyc(1'b0, I_FR, E_RUN, "mdu_rearm");

    cyc(1'b0, I_FR | I_MUL, E_MDUHOLD, "mdu2_c0");
    cyc(1'b0, I_FR | I_MUL, E_MDUHOLD, "mdu2_c1");
    cyc(1'b0, I_FR | I_TRAP, E_TRAP, "mdu_trap");
    cyc(1'b0, I_FR, E_RUN, "mdu_trap_after");

    cyc(1'b0, I_FR | I_MUL, E_MDUHOLD, "mdu3_c0");
    cyc(1'b0, I_FR | I_MUL, E_MDUHOLD, "mdu3_c1");
    cyc(1'b0, I_FR | I_MUL, E_MDUHOLD, "mdu3_c2");
    cyc(1'b0, I_FR, E_MDUDONE, "mdu3_done");

    cyc(1'b0, I_BR, E_BR_WAIT, "br_entry");
    cyc(1'b0, I_NONE, E_REDIR, "redir_wait");
    cyc(1'b0, I_FR, E_REDIR_RDY, "redir_ready");
    cyc(1'b0, I_FR, E_RUN, "redir_after");

    cyc(1'b0, I_FR | I_BR | I_LD, E_BR_READY, "br_ready");
    cyc(1'b0, I_FR, E_RUN, "br_ready_after");

    cyc(1'b0, I_BR, E_BR_WAIT, "br2_entry");
    cyc(1'b0, I_TRAP, E_TRAP, "redir_trap");
    cyc(1'b0, I_FR, E_RUN, "redir_trap_after");

    cyc(1'b0, I_FR | I_TRAP | I_LD | I_BR, E_TRAP, "trap_prio");

    cyc(1'b0, I_FR | I_DREQ, E_DFREEZE, "dmem3_entry");
    cyc(1'b0, I_FR | I_DREQ, E_DFREEZE, "dmem3_wait");
    cyc(1'b1, I_FR | I_DREQ, E_RESET, "rst_mid");
    cyc(1'b0, I_FR, E_RUN, "rst_recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
